// File: rtl/nic_rx_pkg.sv
// Shared types for the NIC receive packet buffer: flit layout, receive FSM states and MAC constants.
package nic_rx_pkg;

    localparam int FLIT_DATA_W = 64;
    localparam int FLIT_KEEP_W = 8;
    localparam int DST_LSB     = 16;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [FLIT_DATA_W-1:0] data;
        logic [FLIT_KEEP_W-1:0] keep;
        logic                   last;
    } flit_t;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        BODY  = 2'd1,
        DROP  = 2'd2
    } rx_state_e;

    function automatic logic [47:0] dst_mac(input logic [FLIT_DATA_W-1:0] data);
        return data[FLIT_DATA_W-1:DST_LSB];
    endfunction

endpackage

// File: rtl/rx_flit_ram.sv
// Flit storage: one synchronous write port, one combinational read port.
// Zero-latency read; no flow control of its own.
module rx_flit_ram
    import nic_rx_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  flit_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output flit_t         o_rdata
);

    flit_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nic_rx_packet_buffer.sv
// MAC-filtering store-and-forward receive buffer; a packet is visible the cycle after its last flit.
// Input has no backpressure (non-fitting packets are dropped whole); output is valid/ready.
module nic_rx_packet_buffer
    import nic_rx_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int BUF_FLITS = 64,
    parameter int PTR_W     = $clog2(BUF_FLITS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic [47:0]       mac_addr,
    input  logic              filter_en,
    output logic [PTR_W:0]    occupancy,
    output logic [15:0]       overflow_drops,
    output logic [15:0]       filter_drops
);

    localparam logic [PTR_W:0] P_DEPTH = (PTR_W+1)'(BUF_FLITS);

    rx_state_e      r_state;
    logic [PTR_W:0] r_head;
    logic [PTR_W:0] r_tail;
    logic [PTR_W:0] r_wr;
    logic [15:0]    r_ovf_drops;
    logic [15:0]    r_flt_drops;

    rx_state_e      w_state_nxt;
    logic [PTR_W:0] w_wr_nxt;
    logic [PTR_W:0] w_tail_nxt;
    logic           w_we;
    logic           w_ovf_inc;
    logic           w_flt_inc;
    logic           w_match;
    logic           w_full;
    logic [PTR_W:0] w_space;
    logic           w_rd;
    flit_t          w_wflit;
    flit_t          w_rflit;

    // Space counts speculative writes against the start-of-cycle head only.
    assign w_space = P_DEPTH - (r_wr - r_head);
    assign w_full  = (w_space == '0);
    assign w_match = (dst_mac(in_data) == mac_addr) || (dst_mac(in_data) == BCAST_MAC);
    assign w_wflit = '{data: in_data, keep: in_keep, last: in_last};

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr;
        w_tail_nxt  = r_tail;
        w_we        = 1'b0;
        w_ovf_inc   = 1'b0;
        w_flt_inc   = 1'b0;
        if (in_valid) begin
            case (r_state)
                FIRST: begin
                    if (filter_en && !w_match) begin
                        w_flt_inc   = 1'b1;
                        w_state_nxt = in_last ? FIRST : DROP;
                    end else if (w_full) begin
                        w_ovf_inc   = 1'b1;
                        w_state_nxt = in_last ? FIRST : DROP;
                    end else begin
                        w_we     = 1'b1;
                        w_wr_nxt = r_wr + 1'b1;
                        if (in_last) begin
                            w_tail_nxt = r_wr + 1'b1;
                        end else begin
                            w_state_nxt = BODY;
                        end
                    end
                end
                BODY: begin
                    if (w_full) begin
                        w_wr_nxt    = r_tail;
                        w_ovf_inc   = 1'b1;
                        w_state_nxt = in_last ? FIRST : DROP;
                    end else begin
                        w_we     = 1'b1;
                        w_wr_nxt = r_wr + 1'b1;
                        if (in_last) begin
                            w_tail_nxt  = r_wr + 1'b1;
                            w_state_nxt = FIRST;
                        end
                    end
                end
                DROP: begin
                    if (in_last) begin
                        w_state_nxt = FIRST;
                    end
                end
                default: w_state_nxt = FIRST;
            endcase
        end
    end

    assign out_valid = (r_head != r_tail);
    assign w_rd      = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FIRST;
            r_head      <= '0;
            r_tail      <= '0;
            r_wr        <= '0;
            r_ovf_drops <= '0;
            r_flt_drops <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr    <= w_wr_nxt;
            r_tail  <= w_tail_nxt;
            if (w_rd) begin
                r_head <= r_head + 1'b1;
            end
            if (w_ovf_inc && (r_ovf_drops != 16'hFFFF)) begin
                r_ovf_drops <= r_ovf_drops + 16'd1;
            end
            if (w_flt_inc && (r_flt_drops != 16'hFFFF)) begin
                r_flt_drops <= r_flt_drops + 16'd1;
            end
        end
    end

    rx_flit_ram #(
        .DEPTH (BUF_FLITS),
        .AW    (PTR_W)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_wr[PTR_W-1:0]),
        .i_wdata (w_wflit),
        .i_raddr (r_head[PTR_W-1:0]),
        .o_rdata (w_rflit)
    );

    assign out_data       = w_rflit.data;
    assign out_keep       = w_rflit.keep;
    assign out_last       = w_rflit.last;
    assign occupancy      = r_tail - r_head;
    assign overflow_drops = r_ovf_drops;
    assign filter_drops   = r_flt_drops;

endmodule
